sa_output_collector: RTL and testbench

//  Receiving end of the systolic-array (SA) row-feed interface: accepts three skewed result lanes,
//  de-skews them, sums the three row partial sums into one 3x3-window result, drops warm-up columns,

---
 rtl/sa_output_collector_if.sv | 22 ++
 rtl/sa_output_collector.sv | 180 ++++++++++++++++++
 tb/tb_sa_output_collector.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_output_collector_if.sv
// SA output collector bus: skewed result lanes in, row-major stream out.
// Master drives lanes and ready; slave (collector) drives the stream.
interface sa_output_collector_if;
  logic               srt_sig;
  logic signed [15:0] in1;
  logic signed [15:0] in2;
  logic signed [15:0] in3;
  logic               out_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_last;

  modport master (
    output srt_sig, in1, in2, in3, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  srt_sig, in1, in2, in3, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/sa_output_collector.sv
// SA output collector: de-skew, 3-row sum, column filter, frame buffer, drain.
// Optional COLLECT_RELU_EN clamps negative sums to zero before storage.
module sa_output_collector #(
  parameter int SIZE = 7,
  parameter int PAD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sa_output_collector_if.slave bus,
  output logic                 busy,
  output logic                 ovf
);
  localparam int I_SIZE = SIZE + 2 * PAD;
  localparam int OSIZE  = I_SIZE - 2;
  localparam int NOUT   = OSIZE * OSIZE;
  localparam int CW     = $clog2(I_SIZE);
  localparam int RW     = (OSIZE > 1) ? $clog2(OSIZE) : 1;
  localparam int AW     = (NOUT > 1) ? $clog2(NOUT) : 1;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  logic [0:0]         state_q;
  logic               s1_q, s2_q, vld_q;
  logic signed [15:0] a1_q, a2_q, b1_q;
  logic signed [15:0] sum_q;
  logic signed [17:0] sum18;
  logic signed [15:0] sat_d;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      orow_q;
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      idx_q;
  logic [AW-1:0]      idx_nx;
  logic               out_valid_q;
  logic signed [15:0] out_data_q;
  logic               out_last_q;
  logic               started_q;
  logic               ovf_q;
  logic signed [15:0] mem [NOUT];
  logic signed [15:0] rd0;

  logic is_collect, is_drain;
  logic wr_en, keep, last_wr, hs, fin, pipe_ok;

  assign is_collect = (state_q == ST_COLLECT);
  assign is_drain   = (state_q == ST_DRAIN);
  assign wr_en      = is_collect && vld_q;
  assign keep       = wr_en && (col_q >= CW'(2));
  assign last_wr    = wr_en && (orow_q == RW'(OSIZE - 1))
                      && (col_q == CW'(I_SIZE - 1));
  assign hs         = out_valid_q && bus.out_ready;
  assign fin        = is_drain && hs && (idx_q == AW'(NOUT - 1));
  assign pipe_ok    = is_collect && !last_wr;
  assign idx_nx     = idx_q + AW'(1);
  assign rd0        = (wptr_q == '0) ? sum_q : mem[0];

  assign sum18 = {{2{a2_q[15]}}, a2_q}
               + {{2{b1_q[15]}}, b1_q}
               + {{2{bus.in3[15]}}, bus.in3};

  // Saturate the aligned row sum to 16 bits (optionally ReLU).
  always_comb begin
    sat_d = sum18[15:0];
    if (sum18 > 18'sd32767) begin
      sat_d = 16'sh7fff;
    end else if (sum18 < -18'sd32768) begin
      sat_d = 16'sh8000;
    end
`ifdef COLLECT_RELU_EN
    if (sat_d[15]) begin
      sat_d = '0;
    end
`endif
  end

  // De-skew lanes and register the saturated sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      vld_q <= 1'b0;
      a1_q  <= '0;
      a2_q  <= '0;
      b1_q  <= '0;
      sum_q <= '0;
    end else begin
      s1_q  <= bus.srt_sig && pipe_ok;
      s2_q  <= s1_q && pipe_ok;
      vld_q <= s2_q && pipe_ok;
      a1_q  <= bus.in1;
      a2_q  <= a1_q;
      b1_q  <= bus.in2;
      sum_q <= sat_d;
    end
  end

  // Column/row window counters and buffer write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      orow_q <= '0;
      wptr_q <= '0;
    end else if (wr_en) begin
      if (col_q == CW'(I_SIZE - 1)) begin
        col_q  <= '0;
        orow_q <= last_wr ? '0 : orow_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
      if (keep) begin
        wptr_q <= last_wr ? '0 : wptr_q + AW'(1);
      end
    end
  end

  // Frame buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (keep) begin
      mem[wptr_q] <= sum_q;
    end
  end

  // Collect/drain FSM with registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        is_collect: begin
          if (last_wr) begin
            state_q     <= ST_DRAIN;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= rd0;
            out_last_q  <= (NOUT == 1);
          end
        end
        is_drain: begin
          if (fin) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else if (hs) begin
            idx_q      <= idx_nx;
            out_data_q <= mem[idx_nx];
            out_last_q <= (idx_nx == AW'(NOUT - 1));
          end
        end
      endcase
    end
  end

  // Frame-activity flag and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (last_wr || fin) begin
        started_q <= 1'b0;
      end else if (is_collect && bus.srt_sig) begin
        started_q <= 1'b1;
      end
      if (is_drain && bus.srt_sig) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = started_q || is_drain;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_sa_output_collector.sv
// Randomized bench for sa_output_collector with a queue-based frame model.
// Directed frames are also pinned against hand-computed literal values.
module tb_sa_output_collector;
  localparam int SIZE  = 7;
  localparam int PAD   = 0;
  localparam int ISZ   = SIZE + 2 * PAD;
  localparam int OSZ   = ISZ - 2;
  localparam int NOUT  = OSZ * OSZ;
  localparam int NSAMP = ISZ * OSZ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic ovf;

  sa_output_collector_if bus();

  sa_output_collector #(.SIZE(SIZE), .PAD(PAD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_srt_cyc = 0;
  int exp_q[$];
  int got_q[$];
  int frame_hs = 0;
  int rmode = 0;
  int stall_n = 0;
  bit prev_valid = 1'b0;
  bit mon_en = 1'b0;

  function automatic int model_sum(int a, int b, int c);
    int s;
    s = a + b + c;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef COLLECT_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: bus.out_ready = ~bus.out_ready;
        default: begin
          if (frame_hs == 12 && stall_n < 5) begin
            bus.out_ready = 1'b0;
            stall_n++;
          end else begin
            bus.out_ready = ~bus.out_ready;
          end
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en) begin
      if (bus.out_valid) begin
        if (!prev_valid) check("latency", cyc - last_srt_cyc, 4);
        check("busy_drain", int'(busy), 1);
        if (exp_q.size() == 0) begin
          fail("spurious_valid", int'(bus.out_data), 0);
        end else begin
          check("data", int'(bus.out_data), exp_q[0]);
          check("last", int'(bus.out_last), int'(frame_hs == NOUT - 1));
          if (bus.out_ready) begin
            got_q.push_back(int'(bus.out_data));
            void'(exp_q.pop_front());
            frame_hs = (frame_hs == NOUT - 1) ? 0 : frame_hs + 1;
          end
        end
      end
      prev_valid = bus.out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send_frame(input int mode, input int gap);
    int a[NSAMP];
    int b[NSAMP];
    int c[NSAMP];
    int k;
    int gap_left;
    bit s, v1, v2;
    int b1, c1, c2;
    k = 0;
    gap_left = 0;
    v1 = 1'b0;
    v2 = 1'b0;
    b1 = 0;
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < NSAMP; i++) begin
      int col;
      col = i % ISZ;
      case (mode)
        1: begin a[i] = 1; b[i] = 1; c[i] = 1; end
        2: begin a[i] = col; b[i] = 10 * col; c[i] = 100 * col; end
        3: begin a[i] = 20000; b[i] = 20000; c[i] = 20000; end
        4: begin a[i] = -20000; b[i] = -20000; c[i] = -20000; end
        default: begin
          a[i] = int'($urandom_range(0, 65535)) - 32768;
          b[i] = int'($urandom_range(0, 65535)) - 32768;
          c[i] = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      if (col >= 2) exp_q.push_back(model_sum(a[i], b[i], c[i]));
    end
    got_q.delete();
    stall_n = 0;
    while (k < NSAMP || v1 || v2) begin
      s = 1'b0;
      if (gap_left > 0) gap_left--;
      else if (k < NSAMP) s = (gap == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.srt_sig = s;
      bus.in1 = s ? 16'(a[k]) : 16'($urandom);
      bus.in2 = v1 ? 16'(b1) : 16'($urandom);
      bus.in3 = v2 ? 16'(c2) : 16'($urandom);
      v2 = v1;
      c2 = c1;
      v1 = s;
      if (s) begin
        b1 = b[k];
        c1 = c[k];
        k++;
        last_srt_cyc = cyc;
        if (gap == 1 && (k % 4) == 0) gap_left = 3;
      end
      @(posedge clk);
      #1;
    end
    bus.srt_sig = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_lit(input int mode);
    check("lit_count", got_q.size(), NOUT);
    for (int i = 0; i < got_q.size() && i < NOUT; i++) begin
      int e;
      case (mode)
        1: e = 3;
        2: e = 111 * ((i % OSZ) + 2);
        3: e = 32767;
        default: begin
`ifdef COLLECT_RELU_EN
          e = 0;
`else
          e = -32768;
`endif
        end
      endcase
      check("lit", got_q[i], e);
    end
  endtask

  task automatic check_idle();
    @(negedge clk);
    check("idle_valid", int'(bus.out_valid), 0);
    check("idle_busy", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    @(negedge clk);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
  endtask

  initial begin
    int n;
    bus.srt_sig = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.in3 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    rmode = 0; send_frame(1, 0); wait_drain(); check_lit(1);
    check_idle();
    rmode = 2; send_frame(2, 0); wait_drain(); check_lit(2);
    rmode = 3; send_frame(3, 0); wait_drain(); check_lit(3);
    rmode = 1; send_frame(4, 0); wait_drain(); check_lit(4);
    rmode = 1; send_frame(2, 1); wait_drain(); check_lit(2);
    check_idle();

    rmode = 0; send_frame(0, 0); wait_drain();
    send_frame(0, 2); wait_drain();
    check_idle();

    check("ovf_before", int'(ovf), 0);
    rmode = 1;
    send_frame(0, 0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_valid) fail("drain_start_timeout", n, 0);
    bus.srt_sig = 1'b1;
    bus.in1 = 16'($urandom);
    @(posedge clk);
    #1;
    bus.srt_sig = 1'b0;
    wait_drain();
    check("ovf_after", int'(ovf), 1);
    check_idle();

    repeat (6) begin
      rmode = int'($urandom_range(0, 3));
      send_frame(0, 2);
      wait_drain();
    end

    rmode = 0;
    send_frame(0, 0);
    n = 0;
    while (frame_hs != 7 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (frame_hs != 7) fail("idx7_timeout", frame_hs, 7);
    rst_n = 1'b0;
    exp_q.delete();
    frame_hs = 0;
    check_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rmode = 2; send_frame(1, 0); wait_drain(); check_lit(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
